// File: rtl/seq_pkg.sv
// seq_pkg: shared icode/stat encodings, sequencer states and instruction decode helpers
// Contents: I_HALT..I_POPQ icodes, STAT_* status codes, state_t FSM states,
//           instr_len(icode) byte length, instr_ok(icode, ifun) legality check.
package seq_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_t;

    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            I_HALT, I_NOP, I_RET:              return 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:  return 4'd2;
            I_JXX, I_CALL:                     return 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      return 4'd10;
            default:                           return 4'd1;
        endcase
    endfunction

    function automatic logic instr_ok(input logic [3:0] ic, input logic [3:0] fn);
        return (ic > I_POPQ) ? 1'b0 :
               (ic == I_OPQ) ? (fn <= 4'd3) :
               (ic == I_RRMOVQ || ic == I_JXX) ? (fn <= 4'd6) : (fn == 4'd0);
    endfunction

endpackage

// File: rtl/seq_fetch_assembler.sv
// seq_fetch_assembler: serial byte fetch, address/legality checks and instruction packing
// Ports: clk, reset (async, active-high); active = parent is in FETCH; pc = fetch base;
//        imem_addr/imem_rd/imem_data = byte-wide memory port (data one cycle after rd);
//        done = last byte captured this cycle; adr_fault/ins_fault = fetch must abort;
//        instr/instr_vld = packed instruction and its one-cycle strobe; icode/ifun = byte 0.
module seq_fetch_assembler
    import seq_pkg::*;
#(
    parameter int IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic [63:0] pc,
    input  logic [7:0]  imem_data,
    output logic [63:0] imem_addr,
    output logic        imem_rd,
    output logic        done,
    output logic        adr_fault,
    output logic        ins_fault,
    output logic [79:0] instr,
    output logic        instr_vld,
    output logic [3:0]  icode,
    output logic [3:0]  ifun
);

    logic [3:0] k;
    logic [3:0] len;
    logic [3:0] cur_len;
    logic       first;
    logic       need_rd;

    // Byte 0 arrives while k==1, so the length is known combinationally in that
    // same cycle and can suppress the read of byte 1 for one-byte instructions.
    assign first     = active && (k == 4'd1);
    assign cur_len   = first ? instr_len(imem_data[7:4]) : len;
    assign ins_fault = first && !instr_ok(imem_data[7:4], imem_data[3:0]);
    assign need_rd   = active && !ins_fault && (k == 4'd0 || k < cur_len);
    assign imem_addr = pc + {60'd0, k};
    assign adr_fault = need_rd && (imem_addr >= 64'(IMEM_DEPTH));
    assign imem_rd   = need_rd && !adr_fault;
    assign done      = active && !ins_fault && (k != 4'd0) && (k == cur_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k         <= '0;
            len       <= '0;
            instr     <= '0;
            instr_vld <= 1'b0;
            icode     <= '0;
            ifun      <= '0;
        end else begin
            k         <= (active && !done && !adr_fault && !ins_fault) ? k + 4'd1 : 4'd0;
            instr_vld <= done;
            if (first) begin
                len   <= cur_len;
                icode <= imem_data[7:4];
                ifun  <= imem_data[3:0];
                instr <= {imem_data, 72'd0};
            end else if (active && k != 4'd0) begin
                instr <= instr | ({imem_data, 72'd0} >> {k - 4'd1, 3'b000});
            end
        end
    end

endmodule

// File: rtl/seq_stage_controller.sv
// seq_stage_controller: multi-cycle Y86-64 SEQ sequencer owning pc, cc and stat
// Ports: clk, reset (async, active-high), start (honoured in IDLE/HALT);
//        imem_addr/imem_rd/imem_data instruction byte port; instr/instr_vld/icode/ifun fetch result;
//        stage_en one-hot {pcupd, writeback, memory, execute, decode}; cc_in/cc flags;
//        new_pc next pc; dmem_error memory fault; pc, stat, halted; cycle_cnt/instr_cnt counters.
// Build option: SEQ_PERF_CNT_EN enables the counters; otherwise both read as zero.
module seq_stage_controller
    import seq_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [63:0]      imem_addr,
    output logic             imem_rd,
    input  logic [7:0]       imem_data,
    output logic [79:0]      instr,
    output logic             instr_vld,
    output logic [3:0]       icode,
    output logic [3:0]       ifun,
    output logic [4:0]       stage_en,
    input  logic [2:0]       cc_in,
    output logic [2:0]       cc,
    input  logic [63:0]      new_pc,
    input  logic             dmem_error,
    output logic [63:0]      pc,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t state;
    logic   fetch_done;
    logic   adr_fault;
    logic   ins_fault;

    seq_fetch_assembler #(
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_fetch (
        .clk       (clk),
        .reset     (reset),
        .active    (state == S_FETCH),
        .pc        (pc),
        .imem_data (imem_data),
        .imem_addr (imem_addr),
        .imem_rd   (imem_rd),
        .done      (fetch_done),
        .adr_fault (adr_fault),
        .ins_fault (ins_fault),
        .instr     (instr),
        .instr_vld (instr_vld),
        .icode     (icode),
        .ifun      (ifun)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            cc       <= 3'b100;
            stat     <= STAT_AOK;
            halted   <= 1'b0;
            stage_en <= '0;
        end else begin
            stage_en <= '0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        cc     <= 3'b100;
                        stat   <= STAT_AOK;
                        halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (adr_fault || ins_fault) begin
                        state  <= S_HALT;
                        stat   <= adr_fault ? STAT_ADR : STAT_INS;
                        halted <= 1'b1;
                    end else if (fetch_done) begin
                        state    <= S_DECODE;
                        stage_en <= 5'b00001;
                    end
                end
                S_DECODE: begin
                    state    <= S_EXECUTE;
                    stage_en <= 5'b00010;
                end
                S_EXECUTE: begin
                    state    <= S_MEMORY;
                    stage_en <= 5'b00100;
                    if (icode == I_OPQ)
                        cc <= cc_in;
                end
                S_MEMORY: begin
                    if (dmem_error) begin
                        state  <= S_HALT;
                        stat   <= STAT_ADR;
                        halted <= 1'b1;
                    end else begin
                        state    <= S_WRITEBACK;
                        stage_en <= 5'b01000;
                    end
                end
                S_WRITEBACK: begin
                    state    <= S_PCUPD;
                    stage_en <= 5'b10000;
                end
                S_PCUPD: begin
                    // A halt walks every stage but leaves pc pointing at itself.
                    if (icode == I_HALT) begin
                        state  <= S_HALT;
                        stat   <= STAT_HLT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                        pc    <= new_pc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (state == S_IDLE || state == S_HALT) begin
            if (start) begin
                cycle_cnt <= '0;
                instr_cnt <= '0;
            end
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state == S_PCUPD && icode != I_HALT)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_stage_controller.sv
// tb_seq_stage_controller: scoreboard bench for seq_stage_controller with directed programs
module tb_seq_stage_controller;

`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rd;
    logic [7:0]  imem_data = 8'h00;
    logic [79:0] instr;
    logic        instr_vld;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [4:0]  stage_en;
    logic [2:0]  cc_in = 3'b000;
    logic [2:0]  cc;
    logic [63:0] new_pc;
    logic        dmem_error;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    logic [7:0]  mem [64];
    logic [63:0] npc_tab [64];
    logic        dmem_err_en = 1'b0;
    logic        bad_rd = 1'b0;

    logic [79:0] exp_q [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          vld_cnt = 0;
    int          stage_cnt = 0;
    int          wb_cnt = 0;

    seq_stage_controller #(.IMEM_DEPTH(64), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_vld  (instr_vld),
        .icode      (icode),
        .ifun       (ifun),
        .stage_en   (stage_en),
        .cc_in      (cc_in),
        .cc         (cc),
        .new_pc     (new_pc),
        .dmem_error (dmem_error),
        .pc         (pc),
        .stat       (stat),
        .halted     (halted),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    assign new_pc     = npc_tab[pc[5:0]];
    assign dmem_error = dmem_err_en && stage_en[2];

    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr[5:0]];
        if (imem_rd && imem_addr >= 64) bad_rd <= 1'b1;
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic monitor;
        forever begin
            @(negedge clk);
            if (stage_en != 5'b0) stage_cnt++;
            if (stage_en[3]) wb_cnt++;
            if (instr_vld) begin
                vld_cnt++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL sb_instr: unexpected instr_vld with instr %0h", instr);
                end else begin
                    chk("sb_instr", instr, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'h00;
            npc_tab[i] = 64'd0;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_vld(input string name, output int n);
        n = 1;
        while (!instr_vld && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!instr_vld) begin
            total_cnt++;
            $display("FAIL %s: no instr_vld within %0d cycles", name, n);
        end
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!halted) begin
            total_cnt++;
            $display("FAIL %s: not halted after %0d cycles", name, n);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_cc"}, cc, 3'b100);
        chk({tag, "_stat"}, stat, 1);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_rd"}, imem_rd, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_instr_vld"}, instr_vld, 0);
        chk({tag, "_icode"}, icode, 0);
        chk({tag, "_ifun"}, ifun, 0);
        chk({tag, "_stage_en"}, stage_en, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
        chk({tag, "_instr_cnt"}, instr_cnt, 0);
    endtask

    initial begin
        int n;
        int v0;
        int s0;
        int w0;
        fork
            monitor();
        join_none
        clear_mem();
        do_reset();
        check_reset_vals("rst");

        // irmovq at 0 (10 bytes), halt at 10
        mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h01;
        npc_tab[0] = 64'd10;
        exp_q.push_back(80'h30F3_0100_0000_0000_0000);
        exp_q.push_back(80'h0);
        pulse_start();
        chk("irm_first_addr", {imem_rd, imem_addr}, {1'b1, 64'd0});
        wait_vld("irm_vld", n);
        chk("irm_vld_latency", n, 12);
        for (int i = 0; i < 5; i++) begin
            chk("irm_stage_walk", stage_en, 5'b00001 << i);
            @(negedge clk);
        end
        chk("irm_new_pc", pc, 10);
        chk("irm_next_fetch", {imem_rd, imem_addr}, {1'b1, 64'd10});
        chk("irm_instr_cnt", instr_cnt, PERF ? 1 : 0);
        wait_halt("irm_halt");
        chk("irm_stat", stat, 2);
        chk("irm_pc_hold", pc, 10);
        chk("irm_cc", cc, 3'b100);
        chk("irm_halt_quiet", {stage_en, imem_rd}, 0);
        chk("irm_sb_empty", exp_q.size(), 0);

        // OPq loads cc, nop does not
        clear_mem();
        do_reset();
        mem[0] = 8'h60; mem[1] = 8'h23; mem[2] = 8'h10; mem[3] = 8'h00;
        npc_tab[0] = 64'd2; npc_tab[2] = 64'd3;
        cc_in = 3'b010;
        exp_q.push_back(80'h6023_0000_0000_0000_0000);
        exp_q.push_back(80'h1000_0000_0000_0000_0000);
        exp_q.push_back(80'h0);
        pulse_start();
        wait_vld("op_vld", n);
        chk("op_vld_latency", n, 4);
        @(negedge clk);
        chk("op_exec_strobe", stage_en, 5'b00010);
        chk("op_cc_before", cc, 3'b100);
        @(negedge clk);
        chk("op_cc_after", cc, 3'b010);
        cc_in = 3'b111;
        wait_halt("op_halt");
        chk("op_cc_nop_hold", cc, 3'b010);
        chk("op_pc", pc, 3);
        chk("op_sb_empty", exp_q.size(), 0);

        // illegal icode C
        clear_mem();
        do_reset();
        mem[0] = 8'hC0;
        v0 = vld_cnt; s0 = stage_cnt;
        pulse_start();
        wait_halt("ins_halt");
        chk("ins_stat", stat, 4);
        chk("ins_halted", halted, 1);
        chk("ins_instr_cnt", instr_cnt, 0);
        chk("ins_no_stage", stage_cnt - s0, 0);
        chk("ins_no_vld", vld_cnt - v0, 0);

        // nop jumps to 60, irmovq there runs off the end of memory
        clear_mem();
        do_reset();
        mem[0] = 8'h10; npc_tab[0] = 64'd60;
        mem[60] = 8'h30; mem[61] = 8'hF3; mem[62] = 8'h01;
        exp_q.push_back(80'h1000_0000_0000_0000_0000);
        v0 = vld_cnt;
        pulse_start();
        wait_halt("adr_halt");
        chk("adr_stat", stat, 3);
        chk("adr_pc", pc, 60);
        chk("adr_no_read64", bad_rd, 0);
        chk("adr_vld_count", vld_cnt - v0, 1);

        // data-memory fault in MEMORY
        clear_mem();
        do_reset();
        mem[0] = 8'h50; mem[1] = 8'h01; mem[2] = 8'h08;
        npc_tab[0] = 64'd10;
        dmem_err_en = 1'b1;
        exp_q.push_back(80'h5001_0800_0000_0000_0000);
        s0 = stage_cnt; w0 = wb_cnt;
        pulse_start();
        wait_halt("dmem_halt");
        dmem_err_en = 1'b0;
        chk("dmem_stat", stat, 3);
        chk("dmem_pc", pc, 0);
        chk("dmem_no_wb", wb_cnt - w0, 0);
        chk("dmem_stages", stage_cnt - s0, 3);

        // async reset mid-fetch of a 10-byte instruction, then refetch from 0
        clear_mem();
        do_reset();
        mem[0] = 8'h10; npc_tab[0] = 64'd1;
        mem[1] = 8'h30; mem[2] = 8'hF3; mem[3] = 8'h01; npc_tab[1] = 64'd11;
        exp_q.push_back(80'h1000_0000_0000_0000_0000);
        exp_q.push_back(80'h30F3_0100_0000_0000_0000);
        pulse_start();
        for (int i = 0; i < 100 && pc != 64'd1; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("mid_icode", icode, 3);
        #2 reset = 1'b1;
        #1 check_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(80'h1000_0000_0000_0000_0000);
        exp_q.push_back(80'h30F3_0100_0000_0000_0000);
        exp_q.push_back(80'h0);
        pulse_start();
        chk("refetch_addr", {imem_rd, imem_addr}, {1'b1, 64'd0});
        wait_halt("refetch_halt");
        chk("refetch_pc", pc, 11);
        chk("refetch_stat", stat, 2);
        chk("refetch_sb_empty", exp_q.size(), 0);

        // restart from HALT with a single halt instruction
        clear_mem();
        exp_q.push_back(80'h0);
        pulse_start();
        chk("restart_stat", stat, 1);
        wait_halt("hlt_halt");
        chk("hlt_stat", stat, 2);
        chk("hlt_pc", pc, 0);
        chk("hlt_cycle_cnt", cycle_cnt, PERF ? 7 : 0);
        chk("hlt_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
